// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end.
// Issues one fetch at a time to instruction memory, forms redirect targets
// (JR > J/JAL > taken branch) from the instruction currently held in if_*,
// parks a returning word in a one-entry skid buffer when decode is stalled,
// and drops any word fetched down a path that a redirect has abandoned.
//
// Handshake: imem_req/imem_addr are held steady from the cycle a request is
// raised until the cycle imem_ack=1 (data in imem_rdata that same cycle);
// if_* is offered to decode while if_valid=1 and is taken on any cycle where
// if_valid=1 and stall=0.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] branch_offset_sl2,
    input  logic        branch_taken,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_BLOCK = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        if_valid_nx;
    logic [31:0] if_pc_nx, if_instr_nx;
    logic        skid_valid, skid_valid_nx;
    logic [31:0] skid_pc, skid_pc_nx, skid_instr, skid_instr_nx;
    logic        kill_pending, kill_pending_nx;
    logic [31:0] kill_target, kill_target_nx;

    logic        redirect;
    logic        slot_free;
    logic [31:0] pc4;
    logic [31:0] target;

    // Redirect decode: only the instruction being handed to decode this cycle may redirect.
    always_comb begin
        pc4      = if_pc + 32'd4;
        redirect = if_valid & ~stall & (jr_en | jump_en | branch_taken);
        if (jr_en) begin
            target = {jr_target[31:2], 2'b00};
        end else if (jump_en) begin
            target = {pc4[31:28], jump_index, 2'b00};
        end else begin
            target = pc4 + branch_offset_sl2;
        end
        slot_free = ~if_valid | ~stall;
    end

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        state_nx        = state;
        pc_nx           = pc;
        if_valid_nx     = if_valid;
        if_pc_nx        = if_pc;
        if_instr_nx     = if_instr;
        skid_valid_nx   = skid_valid;
        skid_pc_nx      = skid_pc;
        skid_instr_nx   = skid_instr;
        kill_pending_nx = kill_pending;
        kill_target_nx  = kill_target;

        // Decode takes the current word (or redirects away from its successor).
        if (if_valid && !stall) begin
            if_valid_nx = 1'b0;
        end

        case (state)
            S_BOOT: begin
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    kill_pending_nx = 1'b0;
                    if (redirect) begin
                        pc_nx = target;
                    end else if (kill_pending) begin
                        pc_nx = kill_target;
                    end else begin
                        pc_nx = pc + 32'd4;
                        if (slot_free) begin
                            if_valid_nx = 1'b1;
                            if_pc_nx    = pc;
                            if_instr_nx = imem_rdata;
                        end else begin
                            skid_valid_nx = 1'b1;
                            skid_pc_nx    = pc;
                            skid_instr_nx = imem_rdata;
                            state_nx      = S_BLOCK;
                        end
                    end
                end else if (redirect) begin
                    // Request already in flight: let it finish, then discard it.
                    kill_pending_nx = 1'b1;
                    kill_target_nx  = target;
                end
            end
            S_BLOCK: begin
                if (redirect) begin
                    skid_valid_nx = 1'b0;
                    pc_nx         = target;
                    state_nx      = S_FETCH;
                end else if (!stall) begin
                    if_valid_nx   = 1'b1;
                    if_pc_nx      = skid_pc;
                    if_instr_nx   = skid_instr;
                    skid_valid_nx = 1'b0;
                    state_nx      = S_FETCH;
                end
            end
            default: begin
                state_nx = S_BOOT;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= 32'd0;
            if_instr     <= 32'd0;
            skid_valid   <= 1'b0;
            skid_pc      <= 32'd0;
            skid_instr   <= 32'd0;
            kill_pending <= 1'b0;
            kill_target  <= 32'd0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            if_valid     <= if_valid_nx;
            if_pc        <= if_pc_nx;
            if_instr     <= if_instr_nx;
            skid_valid   <= skid_valid_nx;
            skid_pc      <= skid_pc_nx;
            skid_instr   <= skid_instr_nx;
            kill_pending <= kill_pending_nx;
            kill_target  <= kill_target_nx;
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dbg_state = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by a randomized run
// checked against an architectural model of the delivered instruction stream.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] branch_offset_sl2;
    logic        branch_taken;
    logic        jump_en;
    logic [25:0] jump_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    int          mem_lat  = 1;   // cycles from request start to ack (1 = same cycle)
    bit          rand_lat = 0;
    bit          busy     = 0;
    int          wait_left = 0;
    logic [31:0] hold_addr = '0;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .branch_offset_sl2(branch_offset_sl2), .branch_taken(branch_taken),
        .jump_en(jump_en), .jump_index(jump_index),
        .jr_en(jr_en), .jr_target(jr_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers the outstanding request after its latency and
    // checks that the address holds while the request waits.
    task automatic mem_drive();
        if (imem_req === 1'b1) begin
            if (!busy) begin
                busy      = 1;
                wait_left = (rand_lat ? $urandom_range(1, 4) : mem_lat) - 1;
                hold_addr = imem_addr;
            end else begin
                chk("addr_stable", imem_addr, hold_addr);
            end
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = word_of(imem_addr);
                busy       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            busy       = 0;
        end
    endtask

    task automatic tick();
        mem_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        branch_taken = 1'b0;
        jump_en      = 1'b0;
        jr_en        = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] pc4;
        int          n_del;
        int          idle;

        rst_n = 1'b0;
        branch_offset_sl2 = '0; branch_taken = 1'b0;
        jump_en = 1'b0; jump_index = '0; jr_en = 1'b0; jr_target = '0;
        stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        // ---- reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        rst_n = 1'b1;

        // ---- zero-wait streaming from reset
        chk("boot_req", imem_req, 0);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", if_valid, 0);
        tick();
        chk("stream_addr1", imem_addr, 32'h4);
        chk("stream_valid", if_valid, 1);
        chk("stream_pc0", if_pc, 32'h0);
        chk("stream_instr0", if_instr, word_of(32'h0));
        tick();
        chk("stream_addr2", imem_addr, 32'h8);
        chk("stream_pc1", if_pc, 32'h4);
        chk("stream_instr1", if_instr, word_of(32'h4));

        // ---- backward branch drops the in-flight 0x14
        repeat (3) tick();
        chk("br_pre_pc", if_pc, 32'h10);
        chk("br_pre_addr", imem_addr, 32'h14);
        branch_taken = 1'b1;
        branch_offset_sl2 = 32'hFFFF_FFF0;
        tick();
        clear_redirect();
        chk("br_addr", imem_addr, 32'h4);
        chk("br_valid_clr", if_valid, 0);
        tick();
        chk("br_land_valid", if_valid, 1);
        chk("br_land_pc", if_pc, 32'h4);

        // ---- jump beats branch, jr beats both
        jr_en = 1'b1; jr_target = 32'h1000_0020;
        tick();
        clear_redirect();
        chk("jr_setup_addr", imem_addr, 32'h1000_0020);
        tick();
        chk("j_pre_pc", if_pc, 32'h1000_0020);
        jump_en = 1'b1; jump_index = 26'h40;
        branch_taken = 1'b1; branch_offset_sl2 = 32'h0000_0400;
        tick();
        clear_redirect();
        chk("j_addr", imem_addr, 32'h1000_0100);
        chk("j_valid_clr", if_valid, 0);
        tick();
        chk("j_land_pc", if_pc, 32'h1000_0100);
        jr_en = 1'b1; jr_target = 32'h2000_0003;
        jump_en = 1'b1; jump_index = 26'h3FF_FFFF;
        branch_taken = 1'b1; branch_offset_sl2 = 32'h0000_0100;
        tick();
        clear_redirect();
        chk("jr_addr", imem_addr, 32'h2000_0000);
        tick();
        chk("jr_land_valid", if_valid, 1);
        chk("jr_land_pc", if_pc, 32'h2000_0000);
        chk("jr_next_addr", imem_addr, 32'h2000_0004);

        // ---- 3-cycle memory, redirect while the request waits
        mem_lat = 3;
        stall = 1'b1;
        tick();
        chk("kill_hold_pc", if_pc, 32'h2000_0000);
        stall = 1'b0;
        jr_en = 1'b1; jr_target = 32'h3000_0000;
        tick();
        clear_redirect();
        chk("kill_addr_hold", imem_addr, 32'h2000_0004);
        chk("kill_valid_clr", if_valid, 0);
        tick();
        chk("kill_new_addr", imem_addr, 32'h3000_0000);
        chk("kill_req", imem_req, 1);
        chk("kill_dropped", if_valid, 0);
        repeat (2) tick();
        chk("kill_wait_valid", if_valid, 0);
        tick();
        chk("kill_land_valid", if_valid, 1);
        chk("kill_land_pc", if_pc, 32'h3000_0000);

        // ---- stall with ack: skid buffer
        mem_lat = 1;
        stall = 1'b1;
        tick();
        chk("skid_req_off", imem_req, 0);
        chk("skid_hold_pc", if_pc, 32'h3000_0000);
        chk("skid_hold_valid", if_valid, 1);
        tick();
        chk("skid_req_off2", imem_req, 0);
        stall = 1'b0;
        tick();
        chk("skid_out_pc", if_pc, 32'h3000_0004);
        chk("skid_out_instr", if_instr, word_of(32'h3000_0004));
        chk("skid_out_valid", if_valid, 1);
        chk("skid_resume_req", imem_req, 1);
        chk("skid_resume_addr", imem_addr, 32'h3000_0008);

        // ---- reset in the middle of a waiting request
        mem_lat = 3;
        stall = 1'b1;
        tick();
        chk("mid_req", imem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_valid", if_valid, 0);
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerst_req", imem_req, 1);
        chk("rerst_addr", imem_addr, RESET_PC);

        // ---- randomized run against the instruction-stream model
        rand_lat = 1;
        exp_pc = RESET_PC;
        n_del = 0;
        idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall        = ($urandom_range(0, 99) < 30);
            jr_en        = ($urandom_range(0, 99) < 10);
            jump_en      = ($urandom_range(0, 99) < 10);
            branch_taken = ($urandom_range(0, 99) < 15);
            jr_target    = $urandom;
            jump_index   = 26'($urandom);
            branch_offset_sl2 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if (if_valid === 1'b1 && !stall) begin
                chk("rand_pc", if_pc, exp_pc);
                chk("rand_instr", if_instr, word_of(exp_pc));
                n_del++;
                idle = 0;
                pc4 = exp_pc + 32'd4;
                if (jr_en)             exp_pc = {jr_target[31:2], 2'b00};
                else if (jump_en)      exp_pc = {pc4[31:28], jump_index, 2'b00};
                else if (branch_taken) exp_pc = pc4 + branch_offset_sl2;
                else                   exp_pc = pc4;
            end else begin
                idle++;
            end
            if (idle > 60) begin
                chk("rand_progress_timeout", idle, 0);
                break;
            end
            tick();
        end
        chk("rand_deliveries", (n_del >= 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter and runs the instruction-fetch handshake with instruction memory.
- Sits directly downstream of the 2-bit left shifter: consumes its shifted, sign-extended branch offset to form PC-relative branch targets.
- Also forms jump and jump-register targets and delivers fetched instructions to decode.
- Contains a one-entry skid buffer and a discard mechanism for wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- branch_offset_sl2  input  32  sign-extended branch offset, already shifted left by 2.
- branch_taken  input  1  decode: branch of instruction in if_* is taken.
- jump_en  input  1  decode: J/JAL in if_*.
- jump_index  input  26  J-format index field.
- jr_en  input  1  decode: JR/JALR in if_*.
- jr_target  input  32  register-sourced target.
- stall  input  1  decode cannot accept; hold if_*.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  if_instr/if_pc valid.
- if_pc  output  32  address of if_instr.
- if_instr  output  32  fetched instruction.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - pc=RESET_PC, state=S_BOOT.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0.
  - skid_valid=0, kill_pending=0.
- Redirect:
  - Redirect is sampled only when if_valid=1 and stall=0.
  - Priority: jr_en > jump_en > branch_taken.
  - jr target = {jr_target[31:2],2'b00}.
  - jump target = {pc4[31:28], jump_index, 2'b00}, where pc4 = if_pc+4.
  - branch target = if_pc + 4 + branch_offset_sl2, mod 2^32 (wrap, no overflow flag).
- S_BOOT: imem_req=0; next cycle go to S_FETCH. First request is asserted 1 cycle after reset release.
- S_FETCH: imem_req=1, imem_addr=pc.
  - Address must stay stable until imem_ack.
  - On ack, pc <= pc+4 unless a redirect occurs (redirect wins).
- Ack with kill_pending=0 and no redirect this cycle:
  - Output slot free (if_valid=0 or stall=0): if_instr<=rdata, if_pc<=imem_addr, if_valid<=1.
  - Otherwise: write to the skid buffer and go to S_BLOCK.
- Ack with redirect in the same cycle, or with kill_pending=1:
  - Data is dropped; kill_pending<=0; pc<=target (on redirect).
- Redirect in S_FETCH without ack:
  - kill_pending<=1, redirect target latched.
  - imem_addr is unchanged until ack, then pc<=latched target.
- Consumption: if_valid=1 and stall=0 with no new data -> if_valid<=0 next cycle.
- Redirect always clears if_valid and skid_valid next cycle; wrong-path data never reaches decode.
- S_BLOCK: imem_req=0.
  - When stall=0, skid contents move to if_* (if_valid=1), skid_valid<=0, then go to S_FETCH.
  - Redirect in S_BLOCK: skid is discarded, pc<=target, go to S_FETCH.
- S_FETCH goes to S_BLOCK also when stall=1 and if_valid=1 at ack time; no new request is issued while the slot and skid are both full.
- Zero-wait memory (ack same cycle as req): back-to-back fetches, one instruction per cycle; if_* is updated 1 cycle after ack.
- Reset mid-transaction: imem_req drops asynchronously; all state is lost; fetch restarts at RESET_PC.
- No delay slot. jr_target low bits are forced to 00 silently.

Test Plan:
- Reset release, zero-wait memory: imem_addr sequence 0x0,0x4,0x8 on consecutive cycles; if_valid rises 1 cycle after first ack; if_pc=0x0 then 0x4.
- if_pc=0x0000_0010, branch_taken=1, branch_offset_sl2=0xFFFF_FFF0: next request address 0x0000_0004; the in-flight 0x14 fetch is dropped (no if_valid for 0x14).
- if_pc=0x1000_0020, jump_en=1, jump_index=26'h40, branch_taken=1 same cycle: target 0x1000_0100 (jump beats branch); jr_en=1, jr_target=0x2000_0003 -> 0x2000_0000 (jr beats both).
- 3-cycle memory latency, redirect 1 cycle after req: imem_addr holds old value until ack, returned word is discarded, next request uses the redirect target.
- stall=1 while if_valid=1 and ack arrives: word goes to skid, imem_req=0; stall released -> skid word appears on if_instr next cycle, fetching resumes at the following address.
- rst_n pulsed low while imem_req=1 (mid-wait): imem_req=0 immediately, if_valid=0; after release the first address is RESET_PC.
